// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, stall and flush.
// Optional build macro ID_EX_PERF_EN adds saturating bubble/flush performance counters.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [13:0]       id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [13:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              hazard_stall
`ifdef ID_EX_PERF_EN
  , output logic [PERF_W-1:0] perf_bubbles
  , output logic [PERF_W-1:0] perf_flushes
`endif
);

  logic uses_rt;
  logic take_bubble;

  // rt is a true source for R-type (aluSrc=0), stores and branches.
  assign uses_rt = !id_ctrl[5] || id_ctrl[10] || id_ctrl[11];

  assign hazard_stall = !flush && id_valid && ex_valid && ex_ctrl[9] &&
                        (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

  assign take_bubble = !flush && !ex_stall && hazard_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard_stall || !id_valid) begin
      // Bubble: control cleared so nothing downstream writes; data left as-is.
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_ctrl  <= id_ctrl;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

`ifdef ID_EX_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (take_bubble && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + PERF_ONE;
      if (flush && (perf_flushes != '1))
        perf_flushes <= perf_flushes + PERF_ONE;
    end
  end
`else
  logic unused_bubble;
  assign unused_bubble = take_bubble;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; perf counter checks only when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe_reg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk, rst, id_valid, flush, ex_stall;
  logic [13:0]       id_ctrl;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              ex_valid, hazard_stall;
  logic [13:0]       ex_ctrl;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_PERF_EN
  logic [1:0]        perf_bubbles, perf_flushes;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [13:0] C_ADD  = 14'h0102;
  localparam logic [13:0] C_LW   = 14'h0320;
  localparam logic [13:0] C_SW   = 14'h0420;
  localparam logic [13:0] C_ADDI = 14'h0120;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .REG_AW(REG_AW)
`ifdef ID_EX_PERF_EN
    , .PERF_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [13:0] c, input logic [31:0] pc4,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v;
    id_ctrl  = c;
    id_pc4   = pc4;
    id_rd1   = pc4 ^ 32'h1111_0000;
    id_rd2   = pc4 ^ 32'h2222_0000;
    id_imm   = pc4 ^ 32'h3333_0000;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL rst_init_valid got=%b exp=0", ex_valid); else pass_cnt++;
    total_cnt++; if (ex_ctrl !== 14'h0) $display("FAIL rst_init_ctrl got=%h exp=0", ex_ctrl); else pass_cnt++;
    rst = 1'b0;
    set_id(1'b1, C_ADD, 32'hAAAA_0104, 5'd1, 5'd2, 5'd3);
    step();
    total_cnt++; if (ex_valid !== 1'b1) $display("FAIL rst_pre_valid got=%b exp=1", ex_valid); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", ex_valid); else pass_cnt++;
    total_cnt++; if (ex_ctrl !== 14'h0) $display("FAIL rst_mid_ctrl got=%h exp=0", ex_ctrl); else pass_cnt++;
    total_cnt++; if (ex_pc4 !== 32'h0) $display("FAIL rst_mid_pc4 got=%h exp=0", ex_pc4); else pass_cnt++;
    total_cnt++; if (ex_rd1 !== 32'h0 || ex_rd2 !== 32'h0 || ex_imm !== 32'h0)
      $display("FAIL rst_mid_data got=%h/%h/%h exp=0", ex_rd1, ex_rd2, ex_imm); else pass_cnt++;
    total_cnt++; if (ex_rs !== 5'd0 || ex_rt !== 5'd0 || ex_rd !== 5'd0)
      $display("FAIL rst_mid_spec got=%0d/%0d/%0d exp=0", ex_rs, ex_rt, ex_rd); else pass_cnt++;
    #1;
    rst = 1'b0;
    set_id(1'b0, 14'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    step();
  endtask

  task automatic test_basic();
    set_id(1'b1, C_ADD, 32'h0000_0104, 5'd1, 5'd2, 5'd3);
    step();
    total_cnt++; if (ex_ctrl !== 14'h0102) $display("FAIL t2_ctrl got=%h exp=0102", ex_ctrl); else pass_cnt++;
    total_cnt++; if (ex_valid !== 1'b1) $display("FAIL t2_valid got=%b exp=1", ex_valid); else pass_cnt++;
    total_cnt++; if (ex_rd !== 5'd3) $display("FAIL t2_rd got=%0d exp=3", ex_rd); else pass_cnt++;
    total_cnt++; if (ex_rd1 !== 32'h1111_0104 || ex_imm !== 32'h3333_0104)
      $display("FAIL t2_data got=%h/%h exp=11110104/33330104", ex_rd1, ex_imm); else pass_cnt++;
    set_id(1'b0, C_ADD, 32'h0000_0999, 5'd9, 5'd9, 5'd9);
    step();
    total_cnt++; if (ex_valid !== 1'b0 || ex_ctrl !== 14'h0)
      $display("FAIL idle_bubble got=%b/%h exp=0/0", ex_valid, ex_ctrl); else pass_cnt++;
    total_cnt++; if (ex_rd !== 5'd3 || ex_pc4 !== 32'h0000_0104)
      $display("FAIL idle_hold got=%0d/%h exp=3/00000104", ex_rd, ex_pc4); else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_id(1'b1, C_LW, 32'h0000_0200, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, C_ADD, 32'h0000_0204, 5'd5, 5'd6, 5'd7);
    #1;
    total_cnt++; if (hazard_stall !== 1'b1) $display("FAIL t3_hz_rs got=%b exp=1", hazard_stall); else pass_cnt++;
    step();
    total_cnt++; if (ex_valid !== 1'b0 || ex_ctrl !== 14'h0)
      $display("FAIL t3_bubble got=%b/%h exp=0/0", ex_valid, ex_ctrl); else pass_cnt++;
    total_cnt++; if (ex_rt !== 5'd5) $display("FAIL t3_bubble_hold got=%0d exp=5", ex_rt); else pass_cnt++;
    total_cnt++; if (hazard_stall !== 1'b0) $display("FAIL t3_release got=%b exp=0", hazard_stall); else pass_cnt++;
    step();
    total_cnt++; if (ex_valid !== 1'b1 || ex_ctrl !== 14'h0102 || ex_rd !== 5'd7)
      $display("FAIL t3_load got=%b/%h/%0d exp=1/0102/7", ex_valid, ex_ctrl, ex_rd); else pass_cnt++;
    set_id(1'b1, C_LW, 32'h0000_0208, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, C_SW, 32'h0000_020C, 5'd1, 5'd5, 5'd0);
    #1;
    total_cnt++; if (hazard_stall !== 1'b1) $display("FAIL t3_hz_rt got=%b exp=1", hazard_stall); else pass_cnt++;
    step();
    step();
    total_cnt++; if (ex_ctrl !== C_SW || ex_valid !== 1'b1)
      $display("FAIL t3_sw_load got=%h/%b exp=0420/1", ex_ctrl, ex_valid); else pass_cnt++;
  endtask

  task automatic test_no_hazard();
    set_id(1'b1, C_LW, 32'h0000_0300, 5'd1, 5'd0, 5'd0);
    step();
    set_id(1'b1, C_ADD, 32'h0000_0304, 5'd0, 5'd0, 5'd4);
    #1;
    total_cnt++; if (hazard_stall !== 1'b0) $display("FAIL t4_r0 got=%b exp=0", hazard_stall); else pass_cnt++;
    step();
    total_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4)
      $display("FAIL t4_r0_load got=%b/%0d exp=1/4", ex_valid, ex_rd); else pass_cnt++;
    set_id(1'b1, C_LW, 32'h0000_0308, 5'd1, 5'd7, 5'd0);
    step();
    set_id(1'b1, C_ADDI, 32'h0000_030C, 5'd2, 5'd7, 5'd0);
    #1;
    total_cnt++; if (hazard_stall !== 1'b0) $display("FAIL t4_addi got=%b exp=0", hazard_stall); else pass_cnt++;
    set_id(1'b1, C_ADD, 32'h0000_030C, 5'd2, 5'd7, 5'd8);
    #1;
    total_cnt++; if (hazard_stall !== 1'b1) $display("FAIL t4_add_rt got=%b exp=1", hazard_stall); else pass_cnt++;
    id_valid = 1'b0;
    #1;
    total_cnt++; if (hazard_stall !== 1'b0) $display("FAIL t4_idle got=%b exp=0", hazard_stall); else pass_cnt++;
    id_valid = 1'b1;
    flush = 1'b1;
    #1;
    total_cnt++; if (hazard_stall !== 1'b0) $display("FAIL t4_flush_hz got=%b exp=0", hazard_stall); else pass_cnt++;
    step();
    total_cnt++; if (ex_valid !== 1'b0 || ex_ctrl !== 14'h0 || ex_rt !== 5'd7)
      $display("FAIL t4_flush got=%b/%h/%0d exp=0/0/7", ex_valid, ex_ctrl, ex_rt); else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_flush_stall();
    set_id(1'b1, C_ADD, 32'h0000_0400, 5'd1, 5'd2, 5'd9);
    step();
    flush = 1'b1;
    ex_stall = 1'b1;
    set_id(1'b1, C_ADD, 32'h0000_0404, 5'd1, 5'd2, 5'd10);
    step();
    total_cnt++; if (ex_valid !== 1'b0 || ex_ctrl !== 14'h0)
      $display("FAIL t5_flush_stall got=%b/%h exp=0/0", ex_valid, ex_ctrl); else pass_cnt++;
    total_cnt++; if (ex_rd !== 5'd9) $display("FAIL t5_flush_hold got=%0d exp=9", ex_rd); else pass_cnt++;
    flush = 1'b0;
    ex_stall = 1'b0;
    set_id(1'b1, C_ADD, 32'h0000_0200, 5'd1, 5'd2, 5'd10);
    step();
    ex_stall = 1'b1;
    set_id(1'b1, C_LW, 32'h0000_0444, 5'd3, 5'd4, 5'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (ex_valid !== 1'b1 || ex_ctrl !== 14'h0102 || ex_rd !== 5'd10 || ex_pc4 !== 32'h0000_0200)
        $display("FAIL t5_stall_%0d got=%b/%h/%0d/%h exp=1/0102/10/00000200", i, ex_valid, ex_ctrl, ex_rd, ex_pc4);
      else pass_cnt++;
    end
    ex_stall = 1'b0;
    set_id(1'b1, C_LW, 32'h0000_0500, 5'd1, 5'd4, 5'd0);
    step();
    ex_stall = 1'b1;
    set_id(1'b1, C_ADD, 32'h0000_0504, 5'd4, 5'd1, 5'd12);
    #1;
    total_cnt++; if (hazard_stall !== 1'b1) $display("FAIL t5_hz_in_stall got=%b exp=1", hazard_stall); else pass_cnt++;
    step();
    total_cnt++; if (ex_ctrl !== C_LW || ex_valid !== 1'b1)
      $display("FAIL t5_stall_hold_lw got=%h/%b exp=0320/1", ex_ctrl, ex_valid); else pass_cnt++;
    ex_stall = 1'b0;
    step();
    total_cnt++; if (ex_valid !== 1'b0 || ex_ctrl !== 14'h0)
      $display("FAIL t5_post_bubble got=%b/%h exp=0/0", ex_valid, ex_ctrl); else pass_cnt++;
    step();
    total_cnt++; if (ex_rd !== 5'd12 || ex_valid !== 1'b1)
      $display("FAIL t5_post_load got=%0d/%b exp=12/1", ex_rd, ex_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, C_ADD | 14'(i), 32'h0000_0600 + 32'(i * 4), 5'(i), 5'(i + 8), 5'(i + 16));
      step();
      total_cnt++; if (ex_ctrl !== (C_ADD | 14'(i)) || ex_rd !== 5'(i + 16) || ex_pc4 !== 32'h0000_0600 + 32'(i * 4))
        $display("FAIL b2b_%0d got=%h/%0d/%h exp=%h/%0d/%h", i, ex_ctrl, ex_rd, ex_pc4,
                 C_ADD | 14'(i), i + 16, 32'h0000_0600 + 32'(i * 4));
      else pass_cnt++;
    end
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    #1;
    total_cnt++; if (perf_bubbles !== 2'd0 || perf_flushes !== 2'd0)
      $display("FAIL perf_rst got=%0d/%0d exp=0/0", perf_bubbles, perf_flushes); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_id(1'b1, C_LW, 32'h0000_0700, 5'd1, 5'd5, 5'd0);
      step();
      set_id(1'b1, C_ADD, 32'h0000_0704, 5'd5, 5'd2, 5'd3);
      step();
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++; if (perf_bubbles !== 2'd2 || perf_flushes !== 2'd1)
      $display("FAIL perf_count got=%0d/%0d exp=2/1", perf_bubbles, perf_flushes); else pass_cnt++;
    flush = 1'b1;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, C_LW, 32'h0000_0800, 5'd1, 5'd6, 5'd0);
      step();
      set_id(1'b1, C_ADD, 32'h0000_0804, 5'd6, 5'd2, 5'd3);
      step();
      step();
    end
    total_cnt++; if (perf_bubbles !== 2'd3 || perf_flushes !== 2'd3)
      $display("FAIL perf_sat got=%0d/%0d exp=3/3", perf_bubbles, perf_flushes); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_stall = 1'b0;
    set_id(1'b0, 14'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_basic();
    test_load_use();
    test_no_hazard();
    test_flush_stall();
    test_back_to_back();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
